// File: rtl/gray_arb_pkg.sv
// gray_arb_pkg: shared defaults and types for the gray image memory arbiter
package gray_arb_pkg;
  localparam int AW_DEF       = 14;
  localparam int DW_DEF       = 8;
  localparam int MAX_HOLD_DEF = 9;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  typedef logic tag_t;
endpackage

// File: rtl/gray_arb_tagq.sv
// gray_arb_tagq: 2-entry in-order FIFO remembering which requester owns each issued read
module gray_arb_tagq
  import gray_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  tag_t tag_i,
  input  logic pop_i,
  output tag_t head_o
);
  tag_t       mem_q [2];
  logic       wp_q, rp_q;
  logic [1:0] cnt_q;
  logic       full;
  assign full   = cnt_q == 2'd2;
  assign head_o = mem_q[rp_q];
  // push on issue, pop on return; reset discards any in-flight owners
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= 1'b0;
      mem_q[1] <= 1'b0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wp_q] <= tag_i;
        wp_q        <= ~wp_q;
      end
      if (pop_i) rp_q <= ~rp_q;
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end
`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push_i && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(pop_i && cnt_q == 2'd0));
`endif
endmodule

// File: rtl/gray_mem_arbiter.sv
// gray_mem_arbiter: two-requester arbiter for the gray image memory read port.
// Define GRAY_ARB_RR_EN for round-robin priority in IDLE; otherwise requester 0 wins.
module gray_mem_arbiter
  import gray_arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    rq_req,
  input  logic [1:0]    rq_lock,
  input  logic [AW-1:0] rq_addr0,
  input  logic [AW-1:0] rq_addr1,
  output logic [1:0]    rq_gnt,
  output logic [1:0]    rq_rvalid,
  output logic [DW-1:0] rq_rdata,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic [DW-1:0] gray_data
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    idle_pick, gnt_raw;
  logic          hold_max, preempt, owner_req, xfer, win_lock;
  tag_t          win, head;
  logic          gray_req_q;
  logic [AW-1:0] gray_addr_q;
  logic [1:0]    rvalid_q;
  logic [DW-1:0] rdata_q;
`ifdef GRAY_ARB_RR_EN
  logic rr_q, rr_d;
  assign idle_pick = (&rq_req) ? (rr_q ? 2'b10 : 2'b01) : rq_req[0] ? 2'b01 : {rq_req[1], 1'b0};
`else
  assign idle_pick = rq_req[0] ? 2'b01 : {rq_req[1], 1'b0};
`endif
  assign hold_max  = hold_q == HW'(MAX_HOLD);
  assign owner_req = (state_q == OWN1) ? rq_req[1] : rq_req[0];
  assign preempt   = hold_max && ((state_q == OWN0 && rq_req[1]) || (state_q == OWN1 && rq_req[0]));
  // owner keeps the port unless its hold budget expired while the other waits
  always_comb begin
    gnt_raw = (state_q == OWN0) ? (preempt ? 2'b10 : {1'b0, rq_req[0]}) :
              (state_q == OWN1) ? (preempt ? 2'b01 : {rq_req[1], 1'b0}) : idle_pick;
  end
  assign rq_gnt   = (reset || !gray_ready) ? 2'b00 : gnt_raw;
  assign xfer     = |rq_gnt;
  assign win      = rq_gnt[1];
  assign win_lock = rq_lock[win];
  // burst ownership and hold counting; the entering transfer counts as the first locked one
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (state_q == IDLE) begin
      if (xfer && win_lock) begin
        state_d = win ? OWN1 : OWN0;
        hold_d  = HW'(1);
      end
    end else if (preempt) begin
      if (xfer) begin
        state_d = IDLE;
        hold_d  = '0;
      end
    end else if (xfer) begin
      if (win_lock) hold_d = hold_max ? hold_q : hold_q + HW'(1);
      else begin
        state_d = IDLE;
        hold_d  = '0;
      end
    end else if (!owner_req) begin
      state_d = IDLE;
      hold_d  = '0;
    end
  end
  // FSM state and hold counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end
`ifdef GRAY_ARB_RR_EN
  // pointer moves to the other requester whenever a transfer or burst completes
  always_comb begin
    rr_d = rr_q;
    if (state_d == IDLE && (xfer || state_q != IDLE)) rr_d = xfer ? ~win : (state_q == OWN0);
  end
  // round-robin pointer, favouring requester 0 after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_q <= 1'b0;
    else rr_q <= rr_d;
  end
`endif
  gray_arb_tagq u_tagq (
    .clk    (clk),
    .reset  (reset),
    .push_i (xfer),
    .tag_i  (win),
    .pop_i  (gray_req_q),
    .head_o (head)
  );
  // issue the read the cycle after the handshake, return data the cycle after that
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gray_req_q  <= 1'b0;
      gray_addr_q <= '0;
      rvalid_q    <= 2'b00;
      rdata_q     <= '0;
    end else begin
      gray_req_q <= xfer;
      if (xfer) gray_addr_q <= win ? rq_addr1 : rq_addr0;
      rvalid_q <= gray_req_q ? (head ? 2'b10 : 2'b01) : 2'b00;
      if (gray_req_q) rdata_q <= gray_data;
    end
  end
  assign gray_req  = gray_req_q;
  assign gray_addr = gray_addr_q;
  assign rq_rvalid = rvalid_q;
  assign rq_rdata  = rdata_q;
endmodule

// File: tb/tb_gray_mem_arbiter.sv
// tb_gray_mem_arbiter: directed checks of grant order, locked bursts, stalls and return routing
module tb_gray_mem_arbiter;
  logic        clk, reset;
  logic [1:0]  rq_req, rq_lock, rq_gnt, rq_rvalid;
  logic [13:0] rq_addr0, rq_addr1, gray_addr;
  logic [7:0]  rq_rdata, gray_data;
  logic        gray_ready, gray_req;
  int          total = 0, bad = 0;
  logic [1:0]  prev_g = 2'b00;
  logic [13:0] prev_a = '0;
  logic [13:0] win_addr [9] = '{14'd0, 14'd1, 14'd2, 14'd128, 14'd129, 14'd130, 14'd256, 14'd257, 14'd258};
  gray_mem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .rq_req     (rq_req),
    .rq_lock    (rq_lock),
    .rq_addr0   (rq_addr0),
    .rq_addr1   (rq_addr1),
    .rq_gnt     (rq_gnt),
    .rq_rvalid  (rq_rvalid),
    .rq_rdata   (rq_rdata),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data)
  );
  function automatic logic [7:0] pix(input logic [13:0] a);
    return (a == 14'd129) ? 8'h5A : (a[7:0] ^ a[13:6]);
  endfunction
  assign gray_data = pix(gray_addr);
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic [1:0] req, input logic [1:0] lock, input logic rdy,
                      input logic [13:0] a0, input logic [13:0] a1, input logic [1:0] eg);
    logic [13:0] ea;
    rq_req = req; rq_lock = lock; gray_ready = rdy; rq_addr0 = a0; rq_addr1 = a1;
    ea = eg[1] ? a1 : a0;
    #1 check({tag, ".gnt"}, 32'(rq_gnt), 32'(eg));
    @(posedge clk); #1;
    check({tag, ".req"}, 32'(gray_req), 32'(|eg));
    if (|eg) check({tag, ".addr"}, 32'(gray_addr), 32'(ea));
    check({tag, ".rvalid"}, 32'(rq_rvalid), 32'(prev_g));
    if (|prev_g) check({tag, ".rdata"}, 32'(rq_rdata), 32'(pix(prev_a)));
    prev_g = eg;
    prev_a = ea;
  endtask
  initial begin
    reset = 1'b1; rq_req = 2'b11; rq_lock = 2'b00; gray_ready = 1'b1; rq_addr0 = '0; rq_addr1 = '0;
    @(posedge clk); #1;
    check("rst.gnt", 32'(rq_gnt), 32'd0);
    check("rst.req", 32'(gray_req), 32'd0);
    check("rst.addr", 32'(gray_addr), 32'd0);
    check("rst.rvalid", 32'(rq_rvalid), 32'd0);
    check("rst.rdata", 32'(rq_rdata), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++)
`ifdef GRAY_ARB_RR_EN
      step("ilv", 2'b11, 2'b00, 1'b1, 14'(10 + i), 14'(200 + i), i[0] ? 2'b10 : 2'b01);
`else
      step("fixed", 2'b11, 2'b00, 1'b1, 14'(10 + i), 14'(200 + i), 2'b01);
`endif
    step("r1", 2'b10, 2'b00, 1'b1, 14'd0, 14'd300, 2'b10);
    step("single", 2'b01, 2'b00, 1'b1, 14'd129, 14'd0, 2'b01);
    step("idle", 2'b00, 2'b00, 1'b1, 14'd0, 14'd0, 2'b00);
    step("idle", 2'b00, 2'b00, 1'b1, 14'd0, 14'd0, 2'b00);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 9; k++)
        step("burst", 2'b11, 2'b01, 1'b1, 14'(win_addr[k] + r * 16), 14'(500 + r), 2'b01);
      step("preempt", 2'b11, 2'b01, 1'b1, 14'd3, 14'(500 + r), 2'b10);
    end
    step("drop_in", 2'b01, 2'b01, 1'b1, 14'd40, 14'd0, 2'b01);
    step("drop", 2'b10, 2'b00, 1'b1, 14'd41, 14'd600, 2'b00);
    step("drop_r1", 2'b10, 2'b00, 1'b1, 14'd41, 14'd601, 2'b10);
    step("pre_stall", 2'b11, 2'b00, 1'b1, 14'd700, 14'd800, 2'b01);
    for (int i = 0; i < 3; i++)
      step("stall", 2'b11, 2'b00, 1'b0, 14'd701, 14'd801, 2'b00);
    step("resume", 2'b01, 2'b00, 1'b1, 14'd702, 14'd0, 2'b01);
    step("idle", 2'b00, 2'b00, 1'b1, 14'd0, 14'd0, 2'b00);
    step("pre_rst", 2'b01, 2'b00, 1'b1, 14'd129, 14'd0, 2'b01);
    reset = 1'b1;
    #1 check("mid_rst.req", 32'(gray_req), 32'd0);
    check("mid_rst.gnt", 32'(rq_gnt), 32'd0);
    rq_req = 2'b00;
    @(posedge clk); #1;
    check("mid_rst.rvalid", 32'(rq_rvalid), 32'd0);
    reset = 1'b0;
    prev_g = 2'b00;
    step("post_rst", 2'b00, 2'b00, 1'b1, 14'd0, 14'd0, 2'b00);
    step("post_rst", 2'b00, 2'b00, 1'b1, 14'd0, 14'd0, 2'b00);
    step("new_rd", 2'b01, 2'b00, 1'b1, 14'd77, 14'd0, 2'b01);
    step("idle", 2'b00, 2'b00, 1'b1, 14'd0, 14'd0, 2'b00);
    step("idle", 2'b00, 2'b00, 1'b1, 14'd0, 14'd0, 2'b00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
